// File: rtl/axi_copy_engine.sv
// AXI4 block-copy manager: reads INCR bursts into a local beat buffer, then
// writes each burst to the destination, never crossing a 4 KB boundary.
module axi_copy_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [15:0]             len_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int BW    = $clog2(MAX_BURST);
    localparam int CW    = BW + 1;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_src, r_dst, r_araddr, r_awaddr;
    logic [15:0]             r_remaining;
    logic [CW-1:0]           r_n, r_beat, r_wbeat;
    logic [7:0]              r_arlen, r_awlen;
    logic                    r_busy, r_done, r_error;
    logic                    r_arvalid, r_rready, r_awvalid, r_wvalid, r_wlast, r_bready;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_buf [MAX_BURST];

    logic [12:0]             w_src_room, w_dst_room, w_src_beats, w_dst_beats;
    logic [16:0]             w_min;
    logic [CW-1:0]           w_beat_inc, w_wnext;
    logic [ADDR_WIDTH-1:0]   w_step;
    logic                    w_buf_we, w_unaligned, w_unused;

    assign w_src_room  = 13'h1000 - {1'b0, r_src[11:0]};
    assign w_dst_room  = 13'h1000 - {1'b0, r_dst[11:0]};
    assign w_src_beats = w_src_room >> SIZE;
    assign w_dst_beats = w_dst_room >> SIZE;
    assign w_beat_inc  = r_beat + CW'(1);
    assign w_wnext     = r_wbeat + CW'(1);
    assign w_step      = ADDR_WIDTH'(r_n) << SIZE;
    assign w_unaligned = (src_addr[SIZE-1:0] != '0) || (dst_addr[SIZE-1:0] != '0);
    assign w_buf_we    = (r_state == S_R) && m_axi_rvalid && (r_beat < CW'(MAX_BURST));
    assign w_unused    = ^{m_axi_rid, m_axi_bid};

    // Burst length: the tightest of remaining work, buffer depth and both 4 KB limits.
    always_comb begin
        w_min = {1'b0, r_remaining};
        if (17'(MAX_BURST) < w_min) w_min = 17'(MAX_BURST);
        if ({4'b0, w_src_beats} < w_min) w_min = {4'b0, w_src_beats};
        if ({4'b0, w_dst_beats} < w_min) w_min = {4'b0, w_dst_beats};
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) r_buf[r_beat[BW-1:0]] <= m_axi_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_araddr    <= '0;
            r_awaddr    <= '0;
            r_remaining <= '0;
            r_n         <= '0;
            r_beat      <= '0;
            r_wbeat     <= '0;
            r_arlen     <= '0;
            r_awlen     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_wdata     <= '0;
            r_bready    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_error <= w_unaligned;
                        if (w_unaligned || len_beats == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_src       <= src_addr;
                            r_dst       <= dst_addr;
                            r_remaining <= len_beats;
                            r_state     <= S_AR;
                        end
                    end
                end
                // First AR cycle loads the burst; valid then holds until arready.
                S_AR: begin
                    if (!r_arvalid) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_src;
                        r_arlen   <= 8'(w_min - 17'd1);
                        r_n       <= w_min[CW-1:0];
                    end else if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (m_axi_rvalid) begin
                        if (r_beat != CW'(MAX_BURST)) r_beat <= w_beat_inc;
                        if (m_axi_rresp != 2'b00) r_error <= 1'b1;
                        if (m_axi_rlast) begin
                            r_rready <= 1'b0;
                            if (m_axi_rresp != 2'b00 || r_error || w_beat_inc != r_n) begin
                                r_error <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_AW;
                            end
                        end
                    end
                end
                S_AW: begin
                    if (!r_awvalid) begin
                        r_awvalid <= 1'b1;
                        r_awaddr  <= r_dst;
                        r_awlen   <= 8'(r_n - CW'(1));
                    end else if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= r_buf[0];
                        r_wlast   <= (r_n == CW'(1));
                        r_wbeat   <= '0;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (m_axi_wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_B;
                        end else begin
                            r_wbeat <= w_wnext;
                            r_wdata <= r_buf[w_wnext[BW-1:0]];
                            r_wlast <= (w_wnext == r_n - CW'(1));
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_src       <= r_src + w_step;
                            r_dst       <= r_dst + w_step;
                            r_remaining <= r_remaining - 16'(r_n);
                            r_state     <= (r_remaining == 16'(r_n)) ? S_DONE : S_AR;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = r_wlast;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
endmodule

// File: tb/tb_axi_copy_engine.sv
// Scoreboard bench for axi_copy_engine: a behavioural AXI4 memory subordinate
// answers the engine, and a negedge monitor checks every handshake and done.
module tb_axi_copy_engine;
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [15:0] len_beats = '0;
    logic        busy, done, error;
    logic [7:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arlock, awlock, arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  arcache, awcache;
    logic [63:0] rdata, wdata;

    always #5 clk = ~clk;

    axi_copy_engine #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(8), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len_beats(len_beats), .busy(busy), .done(done), .error(error),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready)
    );

    int n_checks = 0, n_fail = 0;
    logic [127:0] ar_q[$], aw_q[$], w_q[$];
    logic         done_q[$];
    logic         stall_en = 1'b0, err_inject = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Source content: 0x11..0x88 byte pattern in the first 8 words, address-derived beyond.
    function automatic logic [63:0] pat(input logic [31:0] a);
        logic [31:0] off;
        logic [7:0]  b;
        off = a - BASE;
        b = {5'd0, off[5:3]} + 8'd1;
        if (off < 32'd64) return {8{b * 8'h11}};
        return {a, ~a};
    endfunction

    function automatic logic [10:0] widx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 3;
        return o[10:0];
    endfunction

    logic [63:0] mem [0:2047];
    bit          written [0:2047];

    function automatic logic [63:0] rd_word(input logic [31:0] a);
        return written[widx(a)] ? mem[widx(a)] : pat(a);
    endfunction

    function automatic int stall();
        return stall_en ? int'($urandom_range(5, 0)) : 0;
    endfunction

    // Behavioural AXI4 memory subordinate
    logic [31:0] s_rd_addr, s_wr_addr;
    int          s_rd_left, s_rd_idx, s_rd_burst, s_ar_st, s_r_st, s_aw_st, s_w_st, s_b_st;
    bit          s_rd_act, s_wr_act, s_b_pend;
    assign rid = '0;
    assign bid = '0;

    always @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00; rdata <= '0;
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            s_rd_act <= 1'b0; s_wr_act <= 1'b0; s_b_pend <= 1'b0; s_rd_burst <= 0;
            s_rd_left <= 0; s_rd_idx <= 0; s_rd_addr <= '0; s_wr_addr <= '0;
            s_ar_st <= 0; s_r_st <= 0; s_aw_st <= 0; s_w_st <= 0; s_b_st <= 0;
            for (int i = 0; i < 2048; i++) written[i] <= 1'b0;
        end else begin
            if (!s_rd_act) begin
                if (arvalid && arready) begin
                    arready <= 1'b0; s_rd_act <= 1'b1; s_rd_addr <= araddr;
                    s_rd_left <= int'(arlen) + 1; s_rd_idx <= 0;
                    s_ar_st <= stall(); s_r_st <= stall();
                end else if (arvalid) begin
                    if (s_ar_st == 0) arready <= 1'b1; else s_ar_st <= s_ar_st - 1;
                end
            end else if (rvalid && rready) begin
                rvalid <= 1'b0; rlast <= 1'b0; s_rd_addr <= s_rd_addr + 32'd8;
                s_rd_left <= s_rd_left - 1; s_rd_idx <= s_rd_idx + 1; s_r_st <= stall();
                if (s_rd_left == 1) begin
                    s_rd_act <= 1'b0; s_rd_burst <= s_rd_burst + 1;
                end
            end else if (!rvalid) begin
                if (s_r_st == 0) begin
                    rvalid <= 1'b1; rdata <= rd_word(s_rd_addr); rlast <= (s_rd_left == 1);
                    rresp <= (err_inject && s_rd_burst == 0 && s_rd_idx == 2) ? 2'b10 : 2'b00;
                end else s_r_st <= s_r_st - 1;
            end

            if (!s_wr_act && !s_b_pend) begin
                if (awvalid && awready) begin
                    awready <= 1'b0; s_wr_act <= 1'b1; s_wr_addr <= awaddr; s_w_st <= stall();
                end else if (awvalid) begin
                    if (s_aw_st == 0) awready <= 1'b1; else s_aw_st <= s_aw_st - 1;
                end
            end else if (s_wr_act) begin
                if (wvalid && wready) begin
                    wready <= 1'b0; mem[widx(s_wr_addr)] <= wdata; written[widx(s_wr_addr)] <= 1'b1;
                    s_wr_addr <= s_wr_addr + 32'd8; s_w_st <= stall();
                    if (wlast) begin
                        s_wr_act <= 1'b0; s_b_pend <= 1'b1; s_b_st <= stall();
                    end
                end else if (wvalid) begin
                    if (s_w_st == 0) wready <= 1'b1; else s_w_st <= s_w_st - 1;
                end
            end else begin
                if (bvalid && bready) begin
                    bvalid <= 1'b0; s_b_pend <= 1'b0; s_aw_st <= stall();
                end else if (!bvalid) begin
                    if (s_b_st == 0) begin
                        bvalid <= 1'b1; bresp <= 2'b00;
                    end else s_b_st <= s_b_st - 1;
                end
            end
        end
    end

    // Monitor: compares each handshake against the scoreboard and checks stall stability.
    logic [127:0] ar_act, aw_act, w_act, p_ar, p_aw, p_w;
    bit           p_ar_st = 0, p_aw_st = 0, p_w_st = 0;
    assign ar_act = 128'({araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid});
    assign aw_act = 128'({awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awid});
    assign w_act  = 128'({wdata, wlast, wstrb});

    always @(negedge clk) begin
        if (rst) begin
            p_ar_st = 0; p_aw_st = 0; p_w_st = 0;
        end else begin
            if (arvalid && arready) begin
                check("ar_expected", 128'(ar_q.size() != 0), 128'd1);
                if (ar_q.size() != 0) check("ar", ar_act, ar_q.pop_front());
            end
            if (awvalid && awready) begin
                check("aw_expected", 128'(aw_q.size() != 0), 128'd1);
                if (aw_q.size() != 0) check("aw", aw_act, aw_q.pop_front());
            end
            if (wvalid && wready) begin
                check("w_expected", 128'(w_q.size() != 0), 128'd1);
                if (w_q.size() != 0) check("w", w_act, w_q.pop_front());
            end
            if (done) begin
                check("done_expected", 128'(done_q.size() != 0), 128'd1);
                if (done_q.size() != 0) check("done_error", 128'(error), 128'(done_q.pop_front()));
                check("done_busy", 128'(busy), 128'd0);
            end
            if (p_ar_st) check("ar_stable", {arvalid, ar_act[126:0]}, {1'b1, p_ar[126:0]});
            if (p_aw_st) check("aw_stable", {awvalid, aw_act[126:0]}, {1'b1, p_aw[126:0]});
            if (p_w_st)  check("w_stable", {wvalid, w_act[126:0]}, {1'b1, p_w[126:0]});
            p_ar_st = arvalid && !arready; p_ar = ar_act;
            p_aw_st = awvalid && !awready; p_aw = aw_act;
            p_w_st  = wvalid && !wready;   p_w  = w_act;
        end
    end

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_q.push_back(128'({a, l, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000, 8'h00}));
    endtask
    task automatic push_aw(input logic [31:0] a, input logic [7:0] l);
        aw_q.push_back(128'({a, l, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000, 8'h00}));
    endtask
    task automatic push_w(input logic [31:0] src, input int n);
        for (int i = 0; i < n; i++)
            w_q.push_back(128'({pat(src + 32'(8 * i)), (i == n - 1), 8'hFF}));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        ar_q.delete(); aw_q.delete(); w_q.delete(); done_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; len_beats = n;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!done && cyc < budget);
        check("done_seen", 128'(done), 128'd1);
    endtask

    task automatic check_mem(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++)
            check("mem", 128'(rd_word(d + 32'(8 * i))), 128'(pat(s + 32'(8 * i))));
    endtask

    task automatic check_drained();
        check("ar_drained", 128'(ar_q.size()), 128'd0);
        check("aw_drained", 128'(aw_q.size()), 128'd0);
        check("w_drained", 128'(w_q.size()), 128'd0);
        check("done_drained", 128'(done_q.size()), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, seen;
        repeat (4) @(posedge clk);
        #1;
        check("reset_state", 128'({busy, done, error, arvalid, rready, awvalid, wvalid, wlast, bready,
                                   araddr, arlen, awaddr, awlen, wdata}), 128'd0);
        rst = 1'b0;

        // Single 8-beat burst
        push_ar(32'h0010_0000, 8'd7); push_aw(32'h0010_0100, 8'd7);
        push_w(32'h0010_0000, 8); done_q.push_back(1'b0);
        go(32'h0010_0000, 32'h0010_0100, 16'd8);
        wait_done(400, cyc);
        repeat (2) @(posedge clk);
        check_mem(32'h0010_0000, 32'h0010_0100, 8); check_drained();

        // 40 beats split 16/16/8
        do_reset();
        push_ar(32'h0010_0000, 8'd15); push_ar(32'h0010_0080, 8'd15); push_ar(32'h0010_0100, 8'd7);
        push_aw(32'h0010_0800, 8'd15); push_aw(32'h0010_0880, 8'd15); push_aw(32'h0010_0900, 8'd7);
        push_w(32'h0010_0000, 16); push_w(32'h0010_0080, 16); push_w(32'h0010_0100, 8);
        done_q.push_back(1'b0);
        go(32'h0010_0000, 32'h0010_0800, 16'd40);
        wait_done(1000, cyc);
        repeat (2) @(posedge clk);
        check_mem(32'h0010_0000, 32'h0010_0800, 40); check_drained();

        // Source 4 KB boundary splits 4/4
        do_reset();
        push_ar(32'h0010_0FE0, 8'd3); push_ar(32'h0010_1000, 8'd3);
        push_aw(32'h0010_1400, 8'd3); push_aw(32'h0010_1420, 8'd3);
        push_w(32'h0010_0FE0, 4); push_w(32'h0010_1000, 4); done_q.push_back(1'b0);
        go(32'h0010_0FE0, 32'h0010_1400, 16'd8);
        wait_done(400, cyc);
        repeat (2) @(posedge clk);
        check_mem(32'h0010_0FE0, 32'h0010_1400, 8); check_drained();

        // Random ready stalls on every channel, 16/4 split
        do_reset();
        stall_en = 1'b1;
        push_ar(32'h0010_0000, 8'd15); push_ar(32'h0010_0080, 8'd3);
        push_aw(32'h0010_0200, 8'd15); push_aw(32'h0010_0280, 8'd3);
        push_w(32'h0010_0000, 16); push_w(32'h0010_0080, 4); done_q.push_back(1'b0);
        go(32'h0010_0000, 32'h0010_0200, 16'd20);
        wait_done(3000, cyc);
        repeat (2) @(posedge clk);
        stall_en = 1'b0;
        check_mem(32'h0010_0000, 32'h0010_0200, 20); check_drained();

        // SLVERR on read beat 2: drained to rlast, no write
        do_reset();
        err_inject = 1'b1;
        push_ar(32'h0010_0000, 8'd7); done_q.push_back(1'b1);
        go(32'h0010_0000, 32'h0010_0300, 16'd8);
        wait_done(400, cyc);
        repeat (5) @(posedge clk);
        #1;
        err_inject = 1'b0;
        check("slverr_r_drained", 128'(s_rd_left), 128'd0);
        check("slverr_no_write", 128'(written[widx(32'h0010_0300)]), 128'd0);
        check_drained();

        // Unaligned source: error two cycles after start, error held afterwards
        do_reset();
        done_q.push_back(1'b1);
        go(32'h0010_0004, 32'h0010_0100, 16'd8);
        wait_done(10, cyc);
        check("unaligned_latency", 128'(cyc), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        check("error_held", 128'(error), 128'd1);

        // Zero length: done with error cleared, no traffic
        done_q.push_back(1'b0);
        go(32'h0010_0000, 32'h0010_0100, 16'd0);
        wait_done(10, cyc);
        check("len0_latency", 128'(cyc <= 2), 128'd1);
        repeat (5) @(posedge clk);
        check_drained();

        // Start while busy is ignored
        do_reset();
        push_ar(32'h0010_0000, 8'd7); push_aw(32'h0010_0400, 8'd7);
        push_w(32'h0010_0000, 8); done_q.push_back(1'b0);
        go(32'h0010_0000, 32'h0010_0400, 16'd8);
        repeat (3) @(posedge clk);
        #1;
        check("busy_during_job", 128'(busy), 128'd1);
        go(32'h0010_0000, 32'h0010_0600, 16'd4);
        wait_done(400, cyc);
        repeat (20) @(posedge clk);
        check_mem(32'h0010_0000, 32'h0010_0400, 8);
        check("second_start_no_write", 128'(written[widx(32'h0010_0600)]), 128'd0);
        check_drained();

        // Reset in the middle of the write burst
        do_reset();
        push_ar(32'h0010_0000, 8'd15); push_aw(32'h0010_0700, 8'd15); push_w(32'h0010_0000, 16);
        go(32'h0010_0000, 32'h0010_0700, 16'd16);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!wvalid && cyc < 500);
        check("wvalid_seen", 128'(wvalid), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_wvalid", 128'(wvalid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        ar_q.delete(); aw_q.delete(); w_q.delete(); done_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy || arvalid || awvalid || wvalid) seen++;
        end
        check("idle_after_rst", 128'(seen), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
